pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Receive-side counterpart of the PWM generator: measures an incoming PWM waveform.
//  Reports period and high time in clk cycles, with a one-cycle valid strobe per completed period.
//  Sits on the input pins, next to the generator; results feed the register file.
//  Also used on the bench as a loopback checker for the generator's pwm_out.
// PARAMETERS
//  WIDTH        16  width of the cycle counter and of the period/high results
//  SYNC_STAGES  2   metastability flops on pwm_in (allowed: 2 or 3)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous, active-high reset
//  cap_en       in   1      capture enable; low = idle, results held
//  clr_ovf      in   1      clears sticky ovf_flag
//  pwm_in       in   1      asynchronous PWM input
//  period_out   out  WIDTH  last measured period (rise to rise), in cycles
//  high_out     out  WIDTH  last measured high time (rise to fall), in cycles
//  meas_valid   out  1      1-cycle pulse: period_out/high_out updated this cycle
//  ovf_pulse    out  1      1-cycle pulse: counter saturated, measurement aborted
//  ovf_flag     out  1      sticky overflow; set by ovf_pulse, cleared by clr_ovf or rst
//  level        out  1      synchronized pwm_in level
// BEHAVIOUR
//  Reset:
//   - All outputs 0, synchronizer flops 0, cnt 0, state IDLE.
//  Front end:
//   - pwm_in passes through SYNC_STAGES flops, then one edge-detect flop.
//   - rise/fall are single-cycle strobes.
//   - Latency: pwm_in edge -> rise/fall strobe = SYNC_STAGES+1 cycles.
//   - meas_valid fires on the rise strobe cycle +1 (registered).
//  FSM states:
//   - IDLE: cap_en=0.
//   - ARM: wait for first rise; falls ignored; cnt held.
//   - MEAS_HIGH
//   - MEAS_LOW
//  Transitions:
//   - cap_en=0 from any state -> IDLE next cycle; in-flight measurement discarded; no strobes.
//   - IDLE & cap_en -> ARM.
//   - ARM & rise -> MEAS_HIGH; cnt<=1.
//   - MEAS_HIGH & fall -> MEAS_LOW; high_cap<=cnt; cnt<=cnt+1.
//   - MEAS_LOW & rise -> MEAS_HIGH; period_out<=cnt; high_out<=high_cap; meas_valid=1; cnt<=1.
//   - Otherwise in MEAS_*: cnt<=cnt+1.
//  Counter rules:
//   - cnt value on a strobe cycle = cycles since the previous rise strobe.
//   - Signal high H cycles, low L cycles -> high_out=H, period_out=H+L.
//  Overflow:
//   - In MEAS_*, cnt = 2^WIDTH-1 with no edge that cycle -> ovf_pulse=1, ovf_flag=1, next state ARM.
//   - period_out/high_out are held, not updated.
//   - Covers 0% and 100% duty after arming.
//  Flag clear and reset:
//   - clr_ovf and ovf_pulse in the same cycle: set wins.
//   - rst mid-measurement: immediate return to reset state next cycle; synchronizer also cleared.
//  Signal limits:
//   - Rise and fall cannot coincide (single synchronized level).
//   - Minimum measurable high/low time: 1 cycle.
//  Output hold:
//   - period_out/high_out change only on meas_valid; held through IDLE/ARM.
// STRUCTURE
//  pwm_pkg (shared with the generator):
//   - state enum {IDLE, ARM, MEAS_HIGH, MEAS_LOW}
//   - CNT_W=16 default constant
//   - CNT_MAX function
//  Sub-module pwm_sync_edge:
//   - SYNC_STAGES synchronizer + edge detect
//   - outputs level, rise, fall
//  Top level: FSM, counter, result and flag registers.
//  Estimate ~180 lines RTL.
// TESTING
//  1 Reset: rst=1 with pwm_in toggling -> all outputs 0 and stay 0; no meas_valid.
//  2 Basic: cap_en=1, pwm_in high 3 / low 5 cycles, repeated 4x
//    -> first meas_valid after the 2nd rise; period_out=8, high_out=3.
//    Latency from pwm_in rise to meas_valid = SYNC_STAGES+2.
//  3 Loopback: drive from the generator's pwm_out (period 100, compare1 25, aligned)
//    -> period_out=100, high_out=25 on every meas_valid.
//  4 Overflow: WIDTH=8, pwm_in held high after one rise
//    -> ovf_pulse exactly once, 255 cycles after the rise strobe.
//    ovf_flag=1, state ARM, results unchanged.
//    clr_ovf -> ovf_flag=0; simultaneous clr_ovf+ovf_pulse -> flag stays 1.
//  5 Enable drop: cap_en=0 mid-MEAS_LOW -> no meas_valid, results held.
//    Re-enable -> first valid only after two fresh rises.
//  6 Extremes: high=1/low=1 -> period_out=2, high_out=1.
//    Mid-period rst -> clean restart, first valid matches stimulus.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared types and constants for the PWM generator/capture pair.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } pwm_state_t;

    localparam int CNT_W = 16;

    // All-ones value of a width-bit counter, returned zero-extended to 32 bits.
    function automatic logic [31:0] cnt_max(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sync_edge
// Brief    : Input synchronizer followed by a registered edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    // Strobes are registered alongside the level so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_level <= r_sync[SYNC_STAGES-1];
            r_rise  <= r_sync[SYNC_STAGES-1] & ~r_level;
            r_fall  <= ~r_sync[SYNC_STAGES-1] & r_level;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Brief    : Measures period and high time of an incoming PWM waveform.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH       = CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_en,
    input  logic             clr_ovf,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             meas_valid,
    output logic             ovf_pulse,
    output logic             ovf_flag,
    output logic             level
);

    localparam logic [WIDTH-1:0] c_cnt_max = WIDTH'(cnt_max(WIDTH));
    localparam logic [WIDTH-1:0] c_cnt_one = WIDTH'(1);

    logic             w_level;
    logic             w_rise;
    logic             w_fall;

    pwm_state_t       r_state;
    pwm_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] r_high_cap;
    logic [WIDTH-1:0] w_high_cap_nxt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic             r_meas_valid;
    logic             r_ovf_flag;
    logic             w_meas_done;
    logic             w_ovf;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (w_level),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    // Saturating increment keeps a fall exactly at the limit from wrapping.
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_high_cap_nxt = r_high_cap;
        w_meas_done    = 1'b0;
        w_ovf          = 1'b0;
        if (!cap_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = ARM;
                end
                ARM: begin
                    if (w_rise) begin
                        w_state_nxt = MEAS_HIGH;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
                MEAS_HIGH: begin
                    if (w_fall) begin
                        w_state_nxt    = MEAS_LOW;
                        w_high_cap_nxt = r_cnt;
                        w_cnt_nxt      = w_cnt_inc;
                    end else if (r_cnt == c_cnt_max) begin
                        w_ovf       = 1'b1;
                        w_state_nxt = ARM;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                MEAS_LOW: begin
                    if (w_rise) begin
                        w_state_nxt = MEAS_HIGH;
                        w_meas_done = 1'b1;
                        w_cnt_nxt   = c_cnt_one;
                    end else if (r_cnt == c_cnt_max) begin
                        w_ovf       = 1'b1;
                        w_state_nxt = ARM;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_high_cap   <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_meas_valid <= 1'b0;
            r_ovf_flag   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_high_cap   <= w_high_cap_nxt;
            r_meas_valid <= w_meas_done;
            if (w_meas_done) begin
                r_period <= r_cnt;
                r_high   <= r_high_cap;
            end
            // A new overflow takes priority over a simultaneous clear.
            if (w_ovf) begin
                r_ovf_flag <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf_flag <= 1'b0;
            end
        end
    end

    assign period_out = r_period;
    assign high_out   = r_high;
    assign meas_valid = r_meas_valid;
    assign ovf_pulse  = w_ovf;
    assign ovf_flag   = r_ovf_flag;
    assign level      = w_level;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture
// Brief    : Directed self-checking bench for pwm_capture (WIDTH=8, 2 sync stages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;
    import pwm_pkg::*;

    logic       clk;
    logic       rst;
    logic       cap_en;
    logic       clr_ovf;
    logic       pwm_in;
    logic [7:0] period_out;
    logic [7:0] high_out;
    logic       meas_valid;
    logic       ovf_pulse;
    logic       ovf_flag;
    logic       level;

    int n_pass  = 0;
    int n_total = 0;

    pwm_capture #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .clr_ovf    (clr_ovf),
        .pwm_in     (pwm_in),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .ovf_pulse  (ovf_pulse),
        .ovf_flag   (ovf_flag),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic rearm();
        cap_en = 1'b0;
        @(negedge clk);
        cap_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // reps periods of h high / l low, then tail low cycles; every valid is checked.
    task automatic wave(input int h, input int l, input int reps, input int tail,
                        input int exp_p, input int exp_h,
                        output int nvalid, output int t_first);
        int total;
        total   = reps * (h + l) + tail;
        nvalid  = 0;
        t_first = -1;
        for (int t = 0; t < total; t++) begin
            pwm_in = (t < reps * (h + l)) && ((t % (h + l)) < h);
            @(negedge clk);
            if (meas_valid) begin
                nvalid++;
                if (t_first < 0) t_first = t;
                check("period", 32'(period_out), 32'(exp_p));
                check("high", 32'(high_out), 32'(exp_h));
            end
        end
        pwm_in = 1'b0;
    endtask

    task automatic run_ovf(input logic clr_same, output int n_ovf, output int t_ovf);
        n_ovf = 0;
        t_ovf = -1;
        pwm_in = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (ovf_pulse) begin
                n_ovf++;
                t_ovf   = t;
                clr_ovf = clr_same;
            end else begin
                clr_ovf = 1'b0;
            end
        end
        clr_ovf = 1'b0;
    endtask

    initial begin
        int   nv;
        int   tf;
        int   n_ovf;
        int   t_ovf;
        logic bad;

        // Reset held with a toggling input
        rst = 1'b1; cap_en = 1'b1; clr_ovf = 1'b0; pwm_in = 1'b0; bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pwm_in = i[0];
            @(negedge clk);
            if (meas_valid || ovf_pulse || ovf_flag || level || period_out != 0 || high_out != 0)
                bad = 1'b1;
        end
        check("rst_quiet", 32'(bad), 32'd0);
        check("rst_period", 32'(period_out), 32'd0);
        check("rst_high", 32'(high_out), 32'd0);
        check("rst_valid", 32'(meas_valid), 32'd0);
        check("rst_flag", 32'(ovf_flag), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        rst = 1'b0; pwm_in = 1'b0;
        repeat (4) @(negedge clk);

        // Basic 3 high / 5 low; valid latency after the 2nd rise (t=8)
        wave(3, 5, 4, 6, 8, 3, nv, tf);
        check("basic_nvalid", 32'(nv), 32'd3);
        check("basic_latency", 32'(tf - 8 + 1), 32'd4);

        // Generator-style loopback: period 100, high 25
        rearm();
        wave(25, 75, 3, 6, 100, 25, nv, tf);
        check("loop_nvalid", 32'(nv), 32'd2);

        // Overflow: held high; rise strobe after 3 edges, limit 254 edges later
        rearm();
        run_ovf(1'b0, n_ovf, t_ovf);
        check("ovf_count", 32'(n_ovf), 32'd1);
        check("ovf_time", 32'(t_ovf), 32'd257);
        check("ovf_flag_set", 32'(ovf_flag), 32'd1);
        check("ovf_state", 32'(dut.r_state), 32'(ARM));
        check("ovf_period_held", 32'(period_out), 32'd100);
        check("ovf_high_held", 32'(high_out), 32'd25);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clear", 32'(ovf_flag), 32'd0);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        run_ovf(1'b1, n_ovf, t_ovf);
        check("ovf2_count", 32'(n_ovf), 32'd1);
        check("ovf2_time", 32'(t_ovf), 32'd257);
        @(negedge clk);
        check("ovf_set_wins", 32'(ovf_flag), 32'd1);

        // Enable dropped while in MEAS_LOW
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        rearm();
        for (int t = 0; t < 8; t++) begin
            pwm_in = (t < 3);
            @(negedge clk);
        end
        check("en_state_low", 32'(dut.r_state), 32'(MEAS_LOW));
        cap_en = 1'b0;
        nv = 0;
        for (int t = 0; t < 12; t++) begin
            pwm_in = (t < 3);
            @(negedge clk);
            if (meas_valid) nv++;
        end
        check("en_no_valid", 32'(nv), 32'd0);
        check("en_period_held", 32'(period_out), 32'd100);
        check("en_high_held", 32'(high_out), 32'd25);
        cap_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wave(4, 6, 2, 6, 10, 4, nv, tf);
        check("reen_nvalid", 32'(nv), 32'd1);
        check("reen_first", 32'(tf), 32'd13);

        // Narrowest waveform: 1 high / 1 low
        rearm();
        wave(1, 1, 6, 6, 2, 1, nv, tf);
        check("min_nvalid", 32'(nv), 32'd5);

        // Reset in the middle of a period
        pwm_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_period", 32'(period_out), 32'd0);
        check("mrst_high", 32'(high_out), 32'd0);
        check("mrst_flag", 32'(ovf_flag), 32'd0);
        check("mrst_level", 32'(level), 32'd0);
        pwm_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        wave(2, 4, 3, 6, 6, 2, nv, tf);
        check("mrst_nvalid", 32'(nv), 32'd2);
        check("mrst_first", 32'(tf), 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
